// File: rtl/uart_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_reg_bridge
// Purpose  : Byte-framed UART command decoder driving an 8-bit register bus.
// Revision : 1.0  initial release
// ============================================================================
module uart_reg_bridge #(
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  output logic       rx_rdy_clr,
  output logic [7:0] tx_data,
  output logic       tx_wr_en,
  input  logic       tx_busy,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  output logic       bus_re,
  input  logic [7:0] bus_rdata,
  output logic       frame_err
);

  localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]         c_CMD_WR   = 8'h57;
  localparam logic [7:0]         c_CMD_RD   = 8'h52;
  localparam logic [7:0]         c_ACK      = 8'h4B;
  localparam logic [7:0]         c_NAK      = 8'h3F;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_ADDR  = 3'd1,
    GET_DATA  = 3'd2,
    BUS_WR    = 3'd3,
    BUS_RD    = 3'd4,
    RD_WAIT   = 3'd5,
    SEND      = 3'd6,
    WAIT_BUSY = 3'd7
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_is_write, w_is_write_nxt;
  logic [7:0]         r_bus_addr, w_bus_addr_nxt;
  logic [7:0]         r_bus_wdata, w_bus_wdata_nxt;
  logic [7:0]         r_tx_data, w_tx_data_nxt;
  logic               r_bus_we, w_bus_we_nxt;
  logic               r_bus_re, w_bus_re_nxt;
  logic               r_tx_wr_en, w_tx_wr_en_nxt;
  logic               r_rx_rdy_clr, w_rx_rdy_clr_nxt;
  logic               r_frame_err, w_frame_err_nxt;
  logic [1:0]         r_guard, w_guard_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic w_in_frame;
  logic w_accept;
  logic w_timeout;

  assign w_in_frame = (r_state == GET_ADDR) || (r_state == GET_DATA);
  // The guard spans the two cycles in which the UART may still show the consumed byte.
  assign w_accept   = rx_rdy && (r_guard == 2'd0) && (w_in_frame || (r_state == IDLE));
  assign w_timeout  = w_in_frame && (r_cnt >= c_CNT_LAST);

  always_comb begin
    w_state_nxt      = r_state;
    w_is_write_nxt   = r_is_write;
    w_bus_addr_nxt   = r_bus_addr;
    w_bus_wdata_nxt  = r_bus_wdata;
    w_tx_data_nxt    = r_tx_data;
    w_bus_we_nxt     = 1'b0;
    w_bus_re_nxt     = 1'b0;
    w_tx_wr_en_nxt   = 1'b0;
    w_rx_rdy_clr_nxt = w_accept;
    w_frame_err_nxt  = 1'b0;
    w_guard_nxt      = (r_guard != 2'd0) ? r_guard - 2'd1 : 2'd0;
    w_cnt_nxt        = r_cnt;

    if (w_accept) begin
      w_guard_nxt = 2'd2;
    end

    if (w_accept || !w_in_frame) begin
      w_cnt_nxt = '0;
    end else if (r_cnt != c_CNT_MAX) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if ((rx_data == c_CMD_WR) || (rx_data == c_CMD_RD)) begin
            w_is_write_nxt = (rx_data == c_CMD_WR);
            w_state_nxt    = GET_ADDR;
          end else begin
            w_tx_data_nxt   = c_NAK;
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (w_accept) begin
          w_bus_addr_nxt = rx_data;
          if (r_is_write) begin
            w_state_nxt = GET_DATA;
          end else begin
            w_bus_re_nxt = 1'b1;
            w_state_nxt  = BUS_RD;
          end
        end else if (w_timeout) begin
          w_frame_err_nxt = 1'b1;
          w_state_nxt     = IDLE;
        end
      end
      GET_DATA: begin
        if (w_accept) begin
          w_bus_wdata_nxt = rx_data;
          w_bus_we_nxt    = 1'b1;
          w_state_nxt     = BUS_WR;
        end else if (w_timeout) begin
          w_frame_err_nxt = 1'b1;
          w_state_nxt     = IDLE;
        end
      end
      BUS_WR: begin
        w_tx_data_nxt = c_ACK;
        w_state_nxt   = SEND;
      end
      BUS_RD: begin
        w_state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        w_tx_data_nxt = bus_rdata;
        w_state_nxt   = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          w_tx_wr_en_nxt = 1'b1;
          w_state_nxt    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // Return only once the UART has acknowledged the byte by going busy.
        if (tx_busy) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_is_write   <= 1'b0;
      r_bus_addr   <= 8'h00;
      r_bus_wdata  <= 8'h00;
      r_tx_data    <= 8'h00;
      r_bus_we     <= 1'b0;
      r_bus_re     <= 1'b0;
      r_tx_wr_en   <= 1'b0;
      r_rx_rdy_clr <= 1'b0;
      r_frame_err  <= 1'b0;
      r_guard      <= 2'd0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_is_write   <= w_is_write_nxt;
      r_bus_addr   <= w_bus_addr_nxt;
      r_bus_wdata  <= w_bus_wdata_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_bus_we     <= w_bus_we_nxt;
      r_bus_re     <= w_bus_re_nxt;
      r_tx_wr_en   <= w_tx_wr_en_nxt;
      r_rx_rdy_clr <= w_rx_rdy_clr_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_guard      <= w_guard_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  assign rx_rdy_clr = r_rx_rdy_clr;
  assign tx_data    = r_tx_data;
  assign tx_wr_en   = r_tx_wr_en;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign bus_we     = r_bus_we;
  assign bus_re     = r_bus_re;
  assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_reg_bridge
// Purpose  : Directed scoreboard bench with UART and register-bus models.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_reg_bridge;

  logic       clk_50m   = 1'b0;
  logic       rst_n     = 1'b0;
  logic [7:0] rx_data   = 8'h00;
  logic       rx_rdy    = 1'b0;
  logic       rx_rdy_clr;
  logic [7:0] tx_data;
  logic       tx_wr_en;
  logic       tx_busy   = 1'b0;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata = 8'hEE;
  logic       frame_err;

  int checks = 0, errors = 0, cyc = 0;
  int n_clr = 0, n_we = 0, n_re = 0, n_err = 0, n_tx = 0, exp_clr = 0;
  int last_clr_cyc = 0, last_err_cyc = 0, lat = 0, busy_cnt = 0;
  int t0 = 0, e0 = 0, wait_n = 0;
  logic prev_clr = 1'b0, prev_we = 1'b0, prev_re = 1'b0, prev_err = 1'b0, prev_wr = 1'b0;
  logic hold_busy = 1'b0, rd_pending = 1'b0, rd_drive = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  logic [7:0] mem [256];

  logic [7:0]  exp_tx [$];
  int          exp_lat[$];
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rd [$];

  uart_reg_bridge #(.TIMEOUT_CYCLES(100)) dut (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .rx_rdy_clr(rx_rdy_clr),
    .tx_data   (tx_data),
    .tx_wr_en  (tx_wr_en),
    .tx_busy   (tx_busy),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_rdata (bus_rdata),
    .frame_err (frame_err)
  );

  always #10 clk_50m = ~clk_50m;
  always @(posedge clk_50m) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n       = 0;
    rx_data = b;
    rx_rdy  = 1'b1;
    do begin
      @(negedge clk_50m);
      n++;
    end while (!rx_rdy_clr && n < 50);
    chk("rx_accept", rx_rdy_clr, 1'b1);
    rx_rdy = 1'b0;
    exp_clr++;
    idle(2);
  endtask

  // Bus read data is presented only in the cycle after bus_re; UART goes busy after each write.
  always @(negedge clk_50m) begin
    if (rd_drive) begin
      bus_rdata = 8'hEE;
      rd_drive  = 1'b0;
    end
    if (rd_pending) begin
      bus_rdata  = mem[rd_addr];
      rd_pending = 1'b0;
      rd_drive   = 1'b1;
    end
    if (rx_rdy_clr) begin
      chk("rx_rdy_clr_back2back", prev_clr, 1'b0);
      n_clr++;
      last_clr_cyc = cyc;
    end
    if (bus_we) begin
      chk("bus_we_back2back", prev_we, 1'b0);
      n_we++;
      chk("bus_we_latency", cyc, last_clr_cyc);
      chk("bus_we_expected", exp_wr.size() > 0, 1'b1);
      if (exp_wr.size() > 0) chk("bus_we_addr_data", {bus_addr, bus_wdata}, exp_wr.pop_front());
    end
    if (bus_re) begin
      chk("bus_re_back2back", prev_re, 1'b0);
      n_re++;
      chk("bus_re_latency", cyc, last_clr_cyc);
      chk("bus_re_expected", exp_rd.size() > 0, 1'b1);
      if (exp_rd.size() > 0) chk("bus_re_addr", bus_addr, exp_rd.pop_front());
      rd_pending = 1'b1;
      rd_addr    = bus_addr;
    end
    if (frame_err) begin
      chk("frame_err_back2back", prev_err, 1'b0);
      n_err++;
      last_err_cyc = cyc;
    end
    if (tx_wr_en) begin
      chk("tx_wr_en_back2back", prev_wr, 1'b0);
      n_tx++;
      chk("tx_expected", exp_tx.size() > 0, 1'b1);
      if (exp_tx.size() > 0) begin
        lat = exp_lat.pop_front();
        chk("tx_data", tx_data, exp_tx.pop_front());
        if (lat >= 0) chk("tx_latency", cyc - last_clr_cyc, lat);
      end
      busy_cnt = 4;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy  = hold_busy || (busy_cnt != 0);
    prev_clr = rx_rdy_clr;
    prev_we  = bus_we;
    prev_re  = bus_re;
    prev_err = frame_err;
    prev_wr  = tx_wr_en;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    mem[8'h22] = 8'h5C;
    mem[8'h44] = 8'h99;
    mem[8'h10] = 8'h3C;

    // Reset state
    idle(3);
    chk("rst_rx_rdy_clr", rx_rdy_clr, 1'b0);
    chk("rst_tx_data",    tx_data,    8'h00);
    chk("rst_tx_wr_en",   tx_wr_en,   1'b0);
    chk("rst_bus_addr",   bus_addr,   8'h00);
    chk("rst_bus_wdata",  bus_wdata,  8'h00);
    chk("rst_bus_we",     bus_we,     1'b0);
    chk("rst_bus_re",     bus_re,     1'b0);
    chk("rst_frame_err",  frame_err,  1'b0);
    rst_n = 1'b1;
    idle(2);

    // Write frame
    exp_wr.push_back(16'h10A5); exp_tx.push_back(8'h4B); exp_lat.push_back(2);
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hA5);
    idle(20);
    chk("wr_we_count", n_we, 1);
    chk("wr_tx_count", n_tx, 1);

    // Read frame
    exp_rd.push_back(8'h22); exp_tx.push_back(8'h5C); exp_lat.push_back(3);
    send_byte(8'h52); send_byte(8'h22);
    idle(20);
    chk("rd_re_count", n_re, 1);
    chk("rd_tx_count", n_tx, 2);
    chk("rd_we_count", n_we, 1);

    // Unknown command
    exp_tx.push_back(8'h3F); exp_lat.push_back(1);
    send_byte(8'h00);
    idle(20);
    chk("unk_err_count", n_err, 1);
    chk("unk_err_latency", last_err_cyc, last_clr_cyc);
    chk("unk_we_count", n_we, 1);
    chk("unk_re_count", n_re, 1);
    chk("unk_tx_count", n_tx, 3);

    // Transmitter busy holds the reply
    hold_busy = 1'b1;
    exp_wr.push_back(16'h337E); exp_tx.push_back(8'h4B); exp_lat.push_back(-1);
    send_byte(8'h57); send_byte(8'h33); send_byte(8'h7E);
    idle(50);
    chk("busy_hold_no_tx", n_tx, 3);
    hold_busy = 1'b0;
    idle(20);
    chk("busy_release_tx", n_tx, 4);
    chk("busy_we_count", n_we, 2);

    // rx_rdy held three cycles for one byte
    rx_data = 8'h52;
    rx_rdy  = 1'b1;
    idle(3);
    rx_rdy  = 1'b0;
    exp_clr++;
    idle(2);
    chk("guard_single_accept", n_clr, exp_clr);
    exp_rd.push_back(8'h44); exp_tx.push_back(8'h99); exp_lat.push_back(3);
    send_byte(8'h44);
    idle(20);
    chk("guard_re_count", n_re, 2);
    chk("guard_tx_count", n_tx, 5);

    // Reset between address and data bytes
    send_byte(8'h57); send_byte(8'h10);
    idle(3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_bus_addr", bus_addr, 8'h00);
    chk("async_rst_bus_wdata", bus_wdata, 8'h00);
    chk("async_rst_tx_data", tx_data, 8'h00);
    idle(2);
    rst_n = 1'b1;
    idle(20);
    chk("rst_abort_we_count", n_we, 2);
    chk("rst_abort_tx_count", n_tx, 5);
    exp_tx.push_back(8'h3F); exp_lat.push_back(1);
    send_byte(8'hA5);
    idle(20);
    chk("post_rst_cmd_err", n_err, 2);
    chk("post_rst_cmd_tx", n_tx, 6);

    // Inter-byte timeout
    send_byte(8'h57); send_byte(8'h10);
    t0     = last_clr_cyc;
    e0     = n_err;
    wait_n = 0;
    while (n_err == e0 && wait_n < 150) begin
      @(negedge clk_50m);
      wait_n++;
    end
    chk("timeout_fired", n_err, e0 + 1);
    chk("timeout_latency", last_err_cyc - t0, 100);
    idle(20);
    chk("timeout_no_tx", n_tx, 6);
    chk("timeout_no_we", n_we, 2);
    exp_rd.push_back(8'h10); exp_tx.push_back(8'h3C); exp_lat.push_back(3);
    send_byte(8'h52); send_byte(8'h10);
    idle(20);
    chk("post_timeout_re", n_re, 3);
    chk("post_timeout_tx", n_tx, 7);

    // Scoreboard drained, one clear per accepted byte
    chk("clr_per_byte", n_clr, exp_clr);
    chk("exp_tx_drained", exp_tx.size(), 0);
    chk("exp_wr_drained", exp_wr.size(), 0);
    chk("exp_rd_drained", exp_rd.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
